mem_req_ctrl: RTL and testbench
===============================

Name: mem_req_ctrl

Overview:
- Request front-end between the memory tester/driver and the 16-bit, 64K-word single-port memory array.
- Accepts read and write requests over a valid/ready handshake and buffers them in a small FIFO.
- Issues them to the memory port one at a time, in order.
- Returns read data with a one-cycle response strobe; keeps write/read transaction counters for the bench.

Parameters:
- ADDR_W, 16, address width (64K words).
- DATA_W, 16, data word width.
- FIFO_DEPTH, 4, request FIFO entries; power of two, ≥2.
- RD_LAT, 1, memory read latency in cycles from the mem_en sample edge to mem_rdata valid; 1..3.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept; equals !full.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data; ignored for reads.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable; valid only with mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- rsp_valid  out  1  one-cycle pulse: rsp_data/rsp_addr valid.
- rsp_data  out  DATA_W  read result.
- rsp_addr  out  ADDR_W  address of the read being returned.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- wr_count  out  16  completed memory writes; wraps at 0xFFFF→0.
- rd_count  out  16  completed read responses; wraps at 0xFFFF→0.

Behaviour:
- Reset (rst=1 at a rising edge): all outputs 0, except req_ready=1. FIFO pointers cleared, FSM→IDLE, counters cleared.
- Reset mid-operation: an in-flight read is dropped and no rsp_valid is produced. Buffered requests are discarded.
- Push: occurs at an edge with req_valid && req_ready. A push while full is impossible, because req_ready=0 when full even if a pop happens in the same cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO: both occur; count is unchanged.
- All mem_* and rsp_* outputs are registered.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head and register mem_en=1, mem_we=req_wr, addr, data. Go to WR (write) or RD (read). Otherwise mem_en=0.
  - WR: the memory samples the write at this edge and wr_count increments. If the FIFO is non-empty, pop and issue the next request at the same edge (back-to-back writes give 1 write/cycle). Else mem_en=0 → IDLE.
  - RD: mem_en=0 after the sample edge. Wait RD_LAT cycles, then capture mem_rdata into rsp_data, rsp_addr=issued address, pulse rsp_valid for 1 cycle, increment rd_count → IDLE.
  - A read therefore occupies 1+RD_LAT memory-side cycles; no new issue happens during the wait.
- Latency with RD_LAT=1: push at edge E0, mem_en high after E1, memory samples at E2, rsp_valid high for the cycle after E3.
- Write latency: push at E0, mem_en/mem_we high after E1, write lands at E2.
- Ordering: strict FIFO order. A read after a write to the same address returns the new data, with no bypass required, because the write lands before the read issues.
- mem_we=0 whenever mem_en=0. mem_addr/mem_wdata hold their last value when idle.
- busy=0 only when the FIFO is empty and the FSM is in IDLE with no pending response.

Decomposition:
- mem_pkg holds:
  - typedef mem_addr_t = logic[ADDR_W-1:0]
  - typedef mem_data_t = logic[DATA_W-1:0]
  - packed struct mem_req_t {wr, addr, wdata}
  - enum ctrl_state_e {IDLE, WR, RD}
  - default width constants
- Sub-module mem_req_fifo: synchronous FIFO of mem_req_t with push/pop/full/empty and registered head output. The controller FSM, counters and response register stay in mem_req_ctrl.

Test Plan:
- Reset behaviour: assert rst for 2 cycles with req_valid=1 → req_ready=1, mem_en=0, rsp_valid=0, wr_count=rd_count=0, busy=0.
- Write burst then read-back: write addr 0x0000..0x000F with data = addr, then read 0x0003 → rsp_valid 3 cycles after accept, rsp_data=0x0003, rsp_addr=0x0003; wr_count=16, rd_count=1.
- Back-to-back writes: 16 writes streamed with req_valid held high → mem_en high 16 consecutive cycles with mem_we=1. req_ready drops when 4 entries are buffered.
- Full-FIFO backpressure: stall with 4 reads queued and a 5th presented → req_ready=0 and no push; the 5th is accepted only after the first pop. Responses arrive in order 1..5.
- Read-after-write: write 0x00A5←0xBEEF immediately followed by read 0x00A5 → rsp_data=0xBEEF.
- Reset mid-read: assert rst the cycle after a read's mem_en → no rsp_valid afterwards, rd_count=0, FIFO empty; a subsequent read of 0x0001 returns correctly.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory request front-end.
// Everything here is compile-time only. The default constants are used
// as parameter defaults by the interface and the controller.
package mem_pkg;

    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_RD_LAT     = 1;

    typedef logic [DEF_ADDR_W-1:0] mem_addr_t;
    typedef logic [DEF_DATA_W-1:0] mem_data_t;

    typedef struct packed {
        logic      wr;
        mem_addr_t addr;
        mem_data_t wdata;
    } mem_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Bundle of every bus signal of mem_req_ctrl except clk/rst.
//   request side : req_valid/req_ready/req_wr/req_addr/req_wdata
//   memory side  : mem_en/mem_we/mem_addr/mem_wdata/mem_rdata
//   response     : rsp_valid/rsp_data/rsp_addr
//   status       : busy, wr_count, rd_count
// The slave modport is the controller. The master modport is whoever drives
// requests and models the memory array.
interface mem_req_ctrl_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic              busy;
    logic [15:0]       wr_count;
    logic [15:0]       rd_count;

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, mem_rdata,
        output req_ready, mem_en, mem_we, mem_addr, mem_wdata,
               rsp_valid, rsp_data, rsp_addr, busy, wr_count, rd_count
    );

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, mem_rdata,
        input  req_ready, mem_en, mem_we, mem_addr, mem_wdata,
               rsp_valid, rsp_data, rsp_addr, busy, wr_count, rd_count
    );

endinterface

// File: rtl/mem_req_fifo.sv
// Synchronous request FIFO with a registered head word.
//   clk, rst   : clock, synchronous active-high reset
//   push, din  : write side (ignored while full)
//   pop        : consume head (ignored while empty)
//   head       : registered copy of the oldest entry, valid while !empty
//   full/empty : occupancy flags
module mem_req_fifo
    import mem_pkg::*;
#(
    parameter int WIDTH = 1 + DEF_ADDR_W + DEF_DATA_W,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] head_reg;
    logic [WIDTH-1:0] head_next;
    logic             do_push;
    logic             do_pop;

    assign full       = (count_reg == CNT_W'(DEPTH));
    assign empty      = (count_reg == '0);
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;
    assign head       = head_reg;

    // The head register must already show the next entry on the cycle after
    // a pop, so it looks ahead. When the FIFO is empty, or is being drained
    // to empty, the incoming word goes straight into the head register.
    always_comb begin
        head_next = head_reg;
        if (do_push && (empty || (do_pop && count_reg == CNT_W'(1)))) begin
            head_next = din;
        end else if (do_pop && count_reg > CNT_W'(1)) begin
            head_next = mem_reg[rd_ptr_inc];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            head_reg <= head_next;
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// Request front-end for a single-port synchronous memory.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_req_ctrl_if.slave with the request, memory, response and
//              status signals (see the interface file)
// Requests are buffered in mem_req_fifo and issued in order, one at a time.
// Writes stream at one per cycle. A read holds the memory port until its data
// has been captured and returned as a one-cycle rsp_valid pulse.
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int RD_LAT     = DEF_RD_LAT
) (
    input  logic          clk,
    input  logic          rst,
    mem_req_ctrl_if.slave bus
);
    localparam int         ENTRY_W  = 1 + ADDR_W + DATA_W;
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_WR    = WR;
    localparam logic [1:0] ST_RD    = RD;
    localparam logic [1:0] RD_WAIT  = 2'(RD_LAT);

    logic [ENTRY_W-1:0] fifo_din;
    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               head_wr;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_wdata;

    logic [1:0]         state_reg;
    logic [1:0]         wait_cnt_reg;
    logic               mem_en_reg;
    logic               mem_we_reg;
    logic [ADDR_W-1:0]  mem_addr_reg;
    logic [DATA_W-1:0]  mem_wdata_reg;
    logic               rsp_valid_reg;
    logic [DATA_W-1:0]  rsp_data_reg;
    logic [ADDR_W-1:0]  rsp_addr_reg;
    logic [15:0]        wr_count_reg;
    logic [15:0]        rd_count_reg;

    assign fifo_din = {bus.req_wr, bus.req_addr, bus.req_wdata};
    assign {head_wr, head_addr, head_wdata} = fifo_head;

    // A new request may be issued from IDLE, and from WR at the edge where
    // the memory takes the previous write. No issue is allowed while a read
    // is outstanding.
    assign fifo_pop = !fifo_empty && (state_reg == ST_IDLE || state_reg == ST_WR);

    mem_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.req_valid),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            wait_cnt_reg  <= '0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_addr_reg  <= '0;
            wr_count_reg  <= '0;
            rd_count_reg  <= '0;
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                ST_RD: begin
                    // The first RD edge is the memory sample edge. After it,
                    // count down the read latency and then capture the data.
                    mem_en_reg <= 1'b0;
                    mem_we_reg <= 1'b0;
                    if (wait_cnt_reg == 2'd0) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_data_reg  <= bus.mem_rdata;
                        rsp_addr_reg  <= mem_addr_reg;
                        rd_count_reg  <= rd_count_reg + 16'd1;
                        state_reg     <= ST_IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 2'd1;
                    end
                end
                default: begin
                    // IDLE and WR, plus the unused encoding, which
                    // recovers as IDLE.
                    if (state_reg == ST_WR) begin
                        wr_count_reg <= wr_count_reg + 16'd1;
                    end
                    if (fifo_pop) begin
                        mem_en_reg    <= 1'b1;
                        mem_we_reg    <= head_wr;
                        mem_addr_reg  <= head_addr;
                        mem_wdata_reg <= head_wdata;
                        wait_cnt_reg  <= RD_WAIT;
                        state_reg     <= head_wr ? ST_WR : ST_RD;
                    end else begin
                        mem_en_reg <= 1'b0;
                        mem_we_reg <= 1'b0;
                        state_reg  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.req_ready = !fifo_full;
    assign bus.mem_en    = mem_en_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_addr  = rsp_addr_reg;
    assign bus.busy      = !fifo_empty || (state_reg != ST_IDLE);
    assign bus.wr_count  = wr_count_reg;
    assign bus.rd_count  = rd_count_reg;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl. The bench also models a 64K x 16
// synchronous memory with one cycle of read latency. A reference model built
// from request order (issue queue, response queue, reference memory,
// occupancy) checks the bus on every falling edge.
module tb_mem_req_ctrl;
    import mem_pkg::*;

    typedef struct packed {
        mem_addr_t addr;
        mem_data_t data;
    } rsp_t;

    logic clk;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    mem_req_ctrl_if bus_if ();

    mem_req_ctrl #(
        .ADDR_W     (16),
        .DATA_W     (16),
        .FIFO_DEPTH (4),
        .RD_LAT     (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Reference model state
    mem_req_t  iss_q[$];
    rsp_t      rsp_q[$];
    mem_data_t ref_mem [int];
    mem_data_t mem_arr [int];
    int        acc_total  = 0;
    int        pop_total  = 0;
    int        wr_total   = 0;
    int        rd_total   = 0;
    int        wr_run     = 0;
    int        max_wr_run = 0;
    int        stall_cnt  = 0;
    int        rsp_seen   = 0;
    mem_data_t last_rsp_data = '0;
    mem_addr_t last_rsp_addr = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic mem_data_t init_word(input mem_addr_t a);
        return a ^ 16'h5A5A;
    endfunction

    function automatic mem_data_t ref_read(input mem_addr_t a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
    endfunction

    // Memory array: writes land at the sample edge; read data shows up one cycle later.
    always @(posedge clk) begin
        if (bus_if.mem_en) begin
            if (bus_if.mem_we) begin
                mem_arr[int'(bus_if.mem_addr)] = bus_if.mem_wdata;
            end else begin
                bus_if.mem_rdata <= mem_arr.exists(int'(bus_if.mem_addr)) ?
                                    mem_arr[int'(bus_if.mem_addr)] : init_word(bus_if.mem_addr);
            end
        end
    end

    // Monitor: outputs seen here come from the previous rising edge. Inputs
    // seen here decide what the next rising edge accepts.
    always @(negedge clk) begin
        mem_req_t req;
        rsp_t     exp_rsp;
        if (bus_if.mem_en) begin
            pop_total++;
            if (iss_q.size() == 0) begin
                chk("issue_extra", 32'(bus_if.mem_en), 0);
            end else begin
                req = iss_q.pop_front();
                chk("issue_wr", 32'(bus_if.mem_we), 32'(req.wr));
                chk("issue_addr", 32'(bus_if.mem_addr), 32'(req.addr));
                if (req.wr) chk("issue_wdata", 32'(bus_if.mem_wdata), 32'(req.wdata));
            end
        end else begin
            chk("we_without_en", 32'(bus_if.mem_we), 0);
        end
        if (bus_if.mem_en && bus_if.mem_we) begin
            wr_run++;
            if (wr_run > max_wr_run) max_wr_run = wr_run;
        end else begin
            wr_run = 0;
        end
        if (bus_if.rsp_valid) begin
            rsp_seen++;
            last_rsp_data = bus_if.rsp_data;
            last_rsp_addr = bus_if.rsp_addr;
            if (rsp_q.size() == 0) begin
                chk("rsp_extra", 32'(bus_if.rsp_valid), 0);
            end else begin
                exp_rsp = rsp_q.pop_front();
                chk("rsp_data", 32'(bus_if.rsp_data), 32'(exp_rsp.data));
                chk("rsp_addr", 32'(bus_if.rsp_addr), 32'(exp_rsp.addr));
            end
        end
        chk("req_ready", 32'(bus_if.req_ready), 32'((acc_total - pop_total) < 4));
        if (bus_if.req_valid && !bus_if.req_ready) stall_cnt++;
        if (rst) begin
            iss_q.delete();
            rsp_q.delete();
            acc_total = 0;
            pop_total = 0;
            wr_total  = 0;
            rd_total  = 0;
        end else if (bus_if.req_valid && bus_if.req_ready) begin
            acc_total++;
            req.wr    = bus_if.req_wr;
            req.addr  = bus_if.req_addr;
            req.wdata = bus_if.req_wdata;
            iss_q.push_back(req);
            if (req.wr) begin
                ref_mem[int'(req.addr)] = req.wdata;
                wr_total++;
            end else begin
                exp_rsp.addr = req.addr;
                exp_rsp.data = ref_read(req.addr);
                rsp_q.push_back(exp_rsp);
                rd_total++;
            end
        end
    end

    // Call at posedge+1. Holds the request until a rising edge takes it, and
    // returns at posedge+1 with req_valid still asserted.
    task automatic send(input logic wr, input mem_addr_t addr, input mem_data_t data);
        int guard;
        bus_if.req_valid = 1'b1;
        bus_if.req_wr    = wr;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = data;
        guard = 0;
        forever begin
            @(negedge clk);
            if (bus_if.req_ready) break;
            guard++;
            if (guard > 100) begin
                chk("send_ready", 32'(bus_if.req_ready), 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((bus_if.busy || rsp_q.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_busy", 32'(bus_if.busy), 0);
        chk("drain_rsp_pending", 32'(rsp_q.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int seen_before;
        rst              = 1'b1;
        bus_if.req_valid = 1'b1;
        bus_if.req_wr    = 1'b1;
        bus_if.req_addr  = 16'h1234;
        bus_if.req_wdata = 16'h5678;

        // Reset with a request presented
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus_if.req_ready), 1);
        chk("rst_mem_en", 32'(bus_if.mem_en), 0);
        chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 0);
        chk("rst_wr_count", 32'(bus_if.wr_count), 0);
        chk("rst_rd_count", 32'(bus_if.rd_count), 0);
        chk("rst_busy", 32'(bus_if.busy), 0);
        bus_if.req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(bus_if.busy), 0);
        $display("[TB] reset phase done");

        // Streamed write burst, then a single read-back
        for (int i = 0; i < 16; i++) send(1'b1, 16'(i), 16'(i));
        bus_if.req_valid = 1'b0;
        drain();
        chk("b2b_run", 32'(max_wr_run), 16);
        chk("burst_wr_count", 32'(bus_if.wr_count), 16);
        send(1'b0, 16'h0003, 16'h0000);
        bus_if.req_valid = 1'b0;
        k = 0;
        while (!bus_if.rsp_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("rd_latency", 32'(k), 3);
        chk("rd_back_data", 32'(bus_if.rsp_data), 32'h0003);
        chk("rd_back_addr", 32'(bus_if.rsp_addr), 32'h0003);
        drain();
        chk("rb_wr_count", 32'(bus_if.wr_count), 16);
        chk("rb_rd_count", 32'(bus_if.rd_count), 1);
        $display("[TB] burst and read-back done: wr_count=%0d rd_count=%0d", bus_if.wr_count, bus_if.rd_count);

        // Reads queued faster than they drain, so the FIFO fills up
        stall_cnt = 0;
        for (int i = 1; i <= 8; i++) send(1'b0, 16'(i), 16'h0000);
        bus_if.req_valid = 1'b0;
        drain();
        chk("bp_stalled", 32'(stall_cnt != 0), 1);
        chk("bp_rd_count", 32'(bus_if.rd_count), 32'(rd_total));
        $display("[TB] backpressure done: stall cycles=%0d", stall_cnt);

        // Read immediately after a write to the same address
        send(1'b1, 16'h00A5, 16'hBEEF);
        send(1'b0, 16'h00A5, 16'h0000);
        bus_if.req_valid = 1'b0;
        drain();
        chk("raw_data", 32'(last_rsp_data), 32'hBEEF);
        chk("raw_addr", 32'(last_rsp_addr), 32'h00A5);
        $display("[TB] read-after-write done: data=0x%0h", last_rsp_data);

        // Reset while a read is in flight
        send(1'b0, 16'h0002, 16'h0000);
        bus_if.req_valid = 1'b0;
        k = 0;
        while (!bus_if.mem_en && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("mid_issue", 32'(bus_if.mem_en), 1);
        rst = 1'b1;
        seen_before = rsp_seen;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        chk("mid_no_rsp", 32'(rsp_seen - seen_before), 0);
        chk("mid_rd_count", 32'(bus_if.rd_count), 0);
        chk("mid_wr_count", 32'(bus_if.wr_count), 0);
        chk("mid_busy", 32'(bus_if.busy), 0);
        chk("mid_ready", 32'(bus_if.req_ready), 1);
        send(1'b0, 16'h0001, 16'h0000);
        bus_if.req_valid = 1'b0;
        drain();
        chk("mid_after_addr", 32'(last_rsp_addr), 32'h0001);
        chk("mid_after_data", 32'(last_rsp_data), 32'(ref_read(16'h0001)));
        chk("mid_after_rd_count", 32'(bus_if.rd_count), 1);
        $display("[TB] mid-read reset done: rd_count=%0d", bus_if.rd_count);

        // Randomized mix of reads and writes with idle gaps
        for (int i = 0; i < 300; i++) begin
            send(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                bus_if.req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        bus_if.req_valid = 1'b0;
        drain();
        chk("rand_wr_count", 32'(bus_if.wr_count), 32'(wr_total));
        chk("rand_rd_count", 32'(bus_if.rd_count), 32'(rd_total));
        $display("[TB] random phase done: writes=%0d reads=%0d", wr_total, rd_total);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
